// File: rtl/bram_fifo_ctl.sv
// bram_fifo_ctl: sequencing controller that wraps a simple dual-port block RAM
// with a registered, clock-enabled read port into a first-word-fall-through
// FIFO. The RAM output register doubles as the FIFO head, so the FIFO holds
// up to DEPTH words in RAM plus one word parked in the output register.
module bram_fifo_ctl #(
  parameter int ADDRESSWIDTH = 6,
  parameter int BITWIDTH     = 1,
  parameter int DEPTH        = 34,
  parameter int AFULL_THRESH = 30
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [BITWIDTH-1:0]     wr_data,
  output logic                    wr_afull,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [BITWIDTH-1:0]     rd_data,
  output logic [ADDRESSWIDTH:0]   level,
  output logic [ADDRESSWIDTH-1:0] ram_a,
  output logic [BITWIDTH-1:0]     ram_din,
  output logic                    ram_we,
  output logic [ADDRESSWIDTH-1:0] ram_dpra,
  output logic                    ram_qdpo_ce,
  input  logic [BITWIDTH-1:0]     ram_qdpo
);

  localparam logic [ADDRESSWIDTH:0]   L_DEPTH = (ADDRESSWIDTH+1)'(DEPTH);
  localparam logic [ADDRESSWIDTH-1:0] L_LAST  = ADDRESSWIDTH'(DEPTH-1);
  localparam logic [ADDRESSWIDTH:0]   L_AFULL = (ADDRESSWIDTH+1)'(AFULL_THRESH);

  logic [ADDRESSWIDTH-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDRESSWIDTH:0]   r_ram_cnt;
  logic                    r_rd_valid;

  logic w_push, w_pop;
  logic [ADDRESSWIDTH-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;

  // Handshakes. A pop only sees words counted on earlier edges, so the read
  // address never equals the address being written in the same cycle.
  // The push is masked while reset is held so the RAM is never written then.
  always_comb begin
    wr_ready     = (r_ram_cnt != L_DEPTH) && !flush;
    w_push       = wr_valid && wr_ready && reset_n;
    w_pop        = (r_ram_cnt != '0) && (!r_rd_valid || rd_ready) && !flush;
    w_wr_ptr_nxt = (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + 1'b1;
    w_rd_ptr_nxt = (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + 1'b1;
  end

  // RAM-facing signals and status outputs, all derived from registered state.
  always_comb begin
    ram_a       = r_wr_ptr;
    ram_din     = wr_data;
    ram_we      = w_push;
    ram_dpra    = r_rd_ptr;
    ram_qdpo_ce = w_pop;
    rd_valid    = r_rd_valid;
    rd_data     = r_rd_valid ? ram_qdpo : '0;
    level       = r_ram_cnt + {{ADDRESSWIDTH{1'b0}}, r_rd_valid};
    wr_afull    = (level >= L_AFULL);
  end

  // Pointer, occupancy and head-valid state; flush clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_rd_valid <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop)  r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
        2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
        default: r_ram_cnt <= r_ram_cnt;
      endcase
      if (w_pop)         r_rd_valid <= 1'b1;
      else if (rd_ready) r_rd_valid <= 1'b0;
    end
  end

endmodule
